// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary-to-BCD converter with saturation
module bin2bcd_seq #(
    parameter int IN_W = 7,
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start,
    input  logic [IN_W-1:0]   bin_in,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd_out,
    output logic              ovf
);

    localparam int SW = 4 * NDIG;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [SW-1:0] NINES = {NDIG{4'h9}};
    localparam logic [CW-1:0] LAST_CNT = CW'(IN_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [SW:0]     shifted;
    logic [IN_W-1:0] shift;
    logic [CW-1:0]   cnt;
    logic            sat;
    logic            sat_nxt;
    logic            last;

    // Add-3 correction on every scratch digit that would overflow a decimal digit when doubled.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < NDIG; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // Bit SW of the shifted word is the carry out of the top digit; it is sticky via sat
    // because once the partial value reaches 10^NDIG it can never drop back below it.
    assign shifted = {adj, shift[IN_W-1]};
    assign sat_nxt = sat | shifted[SW];
    assign last    = (cnt == LAST_CNT);
    assign busy    = (state == CONV);

    // State register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept start only from IDLE, leave CONV after the IN_W-th shift.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift one bit per clock, load results on the final shift.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            scratch <= '0;
            shift   <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift   <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        sat     <= 1'b0;
                    end
                end
                CONV: begin
                    scratch <= shifted[SW-1:0];
                    shift   <= shift << 1;
                    cnt     <= cnt + 1'b1;
                    sat     <= sat_nxt;
                    if (last) begin
                        done    <= 1'b1;
                        ovf     <= sat_nxt;
                        bcd_out <= sat_nxt ? NINES : shifted[SW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq in default and 10-bit/3-digit configurations
module tb_bin2bcd_seq;

    localparam int AW = 7;
    localparam int AN = 2;
    localparam int BW = 10;
    localparam int BN = 3;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_ = 1'b0;
    logic            start_a = 1'b0;
    logic [AW-1:0]   bin_a = '0;
    logic            busy_a, done_a, ovf_a;
    logic [4*AN-1:0] bcd_a;
    logic            start_b = 1'b0;
    logic [BW-1:0]   bin_b = '0;
    logic            busy_b, done_b, ovf_b;
    logic [4*BN-1:0] bcd_b;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_a = '{12'h0, 1'b0, 0};
    exp_t last_b = '{12'h0, 1'b0, 0};
    exp_t ea;
    exp_t eb;

    bin2bcd_seq dut_a (
        .clk(clk), .reset_(reset_), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a)
    );

    bin2bcd_seq #(.IN_W(BW), .NDIG(BN)) dut_b (
        .clk(clk), .reset_(reset_), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Decimal digits by repeated division; saturate to all nines at or above 10^nd.
    function automatic exp_t model(input int v, input int nd);
        exp_t e;
        int   lim = 1;
        int   x = v;
        for (int k = 0; k < nd; k++) lim *= 10;
        e.bcd = '0;
        e.ovf = (v >= lim);
        e.cyc = 0;
        for (int k = 0; k < nd; k++) begin
            e.bcd[4*k +: 4] = e.ovf ? 4'd9 : 4'(x % 10);
            x = x / 10;
        end
        return e;
    endfunction

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (reset_) begin
            if (done_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_done", 32'd1, 32'd0);
                end else begin
                    ea = q_a.pop_front();
                    chk("a_bcd", 32'(bcd_a), 32'(ea.bcd));
                    chk("a_ovf", 32'(ovf_a), 32'(ea.ovf));
                    chk("a_latency_cycle", cyc, ea.cyc);
                    last_a = ea;
                end
            end else if (busy_a) begin
                chk("a_hold_bcd", 32'(bcd_a), 32'(last_a.bcd));
                chk("a_hold_ovf", 32'(ovf_a), 32'(last_a.ovf));
            end
        end
    end

    // Monitor for the 10-bit / 3-digit instance.
    always @(negedge clk) begin
        if (reset_) begin
            if (done_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_done", 32'd1, 32'd0);
                end else begin
                    eb = q_b.pop_front();
                    chk("b_bcd", 32'(bcd_b), 32'(eb.bcd));
                    chk("b_ovf", 32'(ovf_b), 32'(eb.ovf));
                    chk("b_latency_cycle", cyc, eb.cyc);
                    last_b = eb;
                end
            end else if (busy_b) begin
                chk("b_hold_bcd", 32'(bcd_b), 32'(last_b.bcd));
                chk("b_hold_ovf", 32'(ovf_b), 32'(last_b.ovf));
            end
        end
    end

    // Issue one start pulse once the selected instance is idle and log its expected result.
    task automatic go(input bit which, input int v, input logic [11:0] bcd, input logic ovf);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while ((which ? busy_b : busy_a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (which ? busy_b : busy_a) chk("wait_idle_timeout", 32'd1, 32'd0);
        e.bcd = bcd;
        e.ovf = ovf;
        e.cyc = cyc + 1 + (which ? BW : AW);
        if (which) begin
            start_b = 1'b1; bin_b = BW'(v); q_b.push_back(e);
        end else begin
            start_a = 1'b1; bin_a = AW'(v); q_a.push_back(e);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_remaining", 32'(q_a.size() + q_b.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        chk({tag, "_done_a"}, 32'(done_a), 32'd0);
        chk({tag, "_bcd_a"},  32'(bcd_a),  32'd0);
        chk({tag, "_ovf_a"},  32'(ovf_a),  32'd0);
        chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        chk({tag, "_bcd_b"},  32'(bcd_b),  32'd0);
    endtask

    initial begin
        int   off;
        int   v;
        int   n;
        exp_t m;

        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset_ = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_done_a", 32'(done_a), 32'd0);
        end
        check_idle_outputs("after_reset");

        go(0, 23, 12'h023, 1'b0);
        go(0, 0, 12'h000, 1'b0);
        go(0, 59, 12'h059, 1'b0);
        go(0, 99, 12'h099, 1'b0);
        go(0, 100, 12'h099, 1'b1);
        go(0, 127, 12'h099, 1'b1);
        go(0, 7, 12'h007, 1'b0);
        drain();

        // Held start: bin_in changes mid-conversion, second accept lands in the done cycle.
        @(negedge clk);
        start_a = 1'b1;
        bin_a = 7'd12;
        q_a.push_back('{12'h012, 1'b0, cyc + 1 + AW});
        @(negedge clk);
        bin_a = 7'd45;
        n = 0;
        while (!done_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("held_start_done_seen", 32'(done_a), 32'd1);
        q_a.push_back('{12'h045, 1'b0, cyc + 1 + AW});
        @(negedge clk);
        start_a = 1'b0;
        drain();

        // Reset during a conversion.
        go(0, 88, 12'h088, 1'b0);
        repeat (3) @(negedge clk);
        reset_ = 1'b0;
        #1;
        q_a.delete();
        last_a = '{12'h0, 1'b0, 0};
        last_b = '{12'h0, 1'b0, 0};
        check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_abort_no_done_a", 32'(done_a), 32'd0);
        end
        go(0, 34, 12'h034, 1'b0);
        drain();

        // Full 0..127 sweep in a random permutation with random gaps.
        off = int'($urandom_range(0, 127));
        for (int i = 0; i < 128; i++) begin
            v = (i * 37 + off) % 128;
            m = model(v, AN);
            go(0, v, m.bcd, m.ovf);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        go(1, 999, 12'h999, 1'b0);
        go(1, 1000, 12'h999, 1'b1);
        go(1, 1023, 12'h999, 1'b1);
        go(1, 405, 12'h405, 1'b0);
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 1023));
            m = model(v, BN);
            go(1, v, m.bcd, m.ovf);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
